count_compare: RTL and testbench

- Compare/PWM stage directly downstream of the team's up-counter.
- Consumes the counter's count value and its terminal strobe.
- Produces a registered PWM output and a match-event stream with a valid/ready handshake.
- Compare value is double-buffered: a config handshake loads a pending register, which moves to the active register only at a period boundary, so the PWM never glitches mid-period.

---
 rtl/count_compare.sv | 118 +++++++++++
 tb/tb_count_compare.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_compare.sv
// Compare/PWM stage fed by the up-counter: double-buffered compare value,
// registered PWM output and a valid/ready match-event stream.
// Optional one-shot mode: define COUNT_COMPARE_ONESHOT_EN to add oneshot/done.
module count_compare #(
  parameter int                     COUNT_WIDTH = 8,
  parameter logic [COUNT_WIDTH-1:0] CMP_RESET   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   period_end,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [COUNT_WIDTH-1:0] cfg_cmp,
  output logic                   pwm_out,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic                   evt_overrun,
  input  logic                   overrun_clr,
`ifdef COUNT_COMPARE_ONESHOT_EN
  input  logic                   oneshot,
  output logic                   done,
`endif
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t                   state, state_nxt;
  logic [COUNT_WIDTH-1:0]   active_cmp;
  logic [COUNT_WIDTH-1:0]   pend_cmp;
  logic                     pend_full;
  logic                     match_q;
  logic                     running;
  logic                     match;
  logic                     evt;
  logic                     cfg_fire;
  logic                     apply;
  logic                     oneshot_end;

  assign running   = (state == RUN);
  assign match     = running && (count == active_cmp);
  assign evt       = match && !match_q;
  assign cfg_ready = !pend_full;
  assign cfg_fire  = cfg_valid && !pend_full;
  // In IDLE nothing is being generated, so a pending value may land at once.
  assign apply     = pend_full && ((state == IDLE) || period_end);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    oneshot_end = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = ARMED;
      ARMED: begin
        if (!enable)         state_nxt = IDLE;
        else if (period_end) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) state_nxt = IDLE;
`ifdef COUNT_COMPARE_ONESHOT_EN
        else if (oneshot && period_end) begin
          state_nxt   = IDLE;
          oneshot_end = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      active_cmp  <= CMP_RESET;
      pend_full   <= 1'b0;
      match_q     <= 1'b0;
      pwm_out     <= 1'b0;
      evt_valid   <= 1'b0;
      evt_overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      match_q <= match;
      pwm_out <= running && (count < active_cmp);

      if (apply) begin
        active_cmp <= pend_cmp;
        pend_full  <= 1'b0;
      end else if (cfg_fire) begin
        pend_full  <= 1'b1;
      end

      if (evt)            evt_valid <= 1'b1;
      else if (evt_ready) evt_valid <= 1'b0;

      if (evt && evt_valid && !evt_ready) evt_overrun <= 1'b1;
      else if (overrun_clr)               evt_overrun <= 1'b0;
    end
  end

  // Pending compare value: data only, qualified by pend_full
  always_ff @(posedge clk) begin
    if (cfg_fire) pend_cmp <= cfg_cmp;
  end

`ifdef COUNT_COMPARE_ONESHOT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) done <= 1'b0;
    else      done <= oneshot_end;
  end
`else
  logic unused_oneshot;
  assign unused_oneshot = oneshot_end;
`endif

endmodule

// File: tb/tb_count_compare.sv
// Directed bench for count_compare: cycle table for the handshake/FSM corners,
// then full 8-bit counter periods against a small compare/PWM reference.
module tb_count_compare;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] count;
  logic       period_end;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_cmp;
  logic       pwm_out;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_overrun;
  logic       overrun_clr;
  logic       busy;
`ifdef COUNT_COMPARE_ONESHOT_EN
  logic       oneshot = 1'b0;
  logic       done;
`endif

  count_compare #(.COUNT_WIDTH(8), .CMP_RESET(8'd0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .count(count), .period_end(period_end),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cmp(cfg_cmp),
    .pwm_out(pwm_out), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_overrun(evt_overrun), .overrun_clr(overrun_clr),
`ifdef COUNT_COMPARE_ONESHOT_EN
    .oneshot(oneshot), .done(done),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] cnt;
    logic       pe;
    logic       cv;
    logic [7:0] cc;
    logic       er;
    logic       oc;
    logic       pwm;
    logic       ev;
    logic       ov;
    logic       cr;
    logic       bsy;
  } vec_t;

  vec_t vecs [30];

  int n_vec = 0;
  int n_bad = 0;

  // Reference state for the full-period sequences
  logic [7:0] cur_m, pend_m;
  logic       full_m, run_m, prev_ev;
  int         rises;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cur_m   = 8'd0;
    pend_m  = 8'd0;
    full_m  = 1'b0;
    run_m   = 1'b0;
    prev_ev = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; count = 8'd0; period_end = 1'b0;
    cfg_valid = 1'b0; cfg_cmp = 8'd0; evt_ready = 1'b1; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  // One counter cycle in ARMED/RUN with the reference updated alongside.
  task automatic cyc(input logic [7:0] c, input logic cv, input logic [7:0] cc);
    logic exp_pwm, pre_full, pe;
    pe = (c == 8'd255);
    count = c; period_end = pe; cfg_valid = cv; cfg_cmp = cc;
    exp_pwm  = run_m && (c < cur_m);
    pre_full = full_m;
    if (pe && full_m) begin cur_m = pend_m; full_m = 1'b0; end
    if (cv && !pre_full) begin pend_m = cc; full_m = 1'b1; end
    if (pe && enable) run_m = 1'b1;
    @(posedge clk);
    #1;
    chk1($sformatf("pwm c=%0d cmp=%0d", c, cur_m), pwm_out, exp_pwm);
    chk1($sformatf("cfg_ready c=%0d", c), cfg_ready, !full_m);
    if (evt_valid && !prev_ev) rises++;
    prev_ev   = evt_valid;
    cfg_valid = 1'b0;
    period_end = 1'b0;
  endtask

  task automatic run_period(input int cfg_at, input logic [7:0] cfg_val,
                            input int exp_rises, input string nm);
    rises = 0;
    for (int c = 0; c < 256; c++) cyc(8'(c), (c == cfg_at), cfg_val);
    if (exp_rises >= 0) chk_int(nm, rises, exp_rises);
  endtask

  initial begin
    // en cnt pe cv cc er oc | pwm ev ov cr busy
    vecs[0]  = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 8'd5, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 8'd2, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'd5, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'd5, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 8'd2, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[20] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[21] = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[22] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[23] = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[24] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[25] = '{1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[26] = '{1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[27] = '{1'b0, 8'd2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[28] = '{1'b0, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[29] = '{1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; enable = 1'b0; count = 8'd0; period_end = 1'b0;
    cfg_valid = 1'b0; cfg_cmp = 8'd0; evt_ready = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst pwm_out", pwm_out, 1'b0);
    chk1("rst evt_valid", evt_valid, 1'b0);
    chk1("rst evt_overrun", evt_overrun, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst cfg_ready", cfg_ready, 1'b1);
    rst = 1'b1;

    // Cycle table: small compare values, hand-driven count and strobe
    for (int i = 0; i < 30; i++) begin
      enable = vecs[i].en; count = vecs[i].cnt; period_end = vecs[i].pe;
      cfg_valid = vecs[i].cv; cfg_cmp = vecs[i].cc;
      evt_ready = vecs[i].er; overrun_clr = vecs[i].oc;
      @(posedge clk);
      #1;
      chk1($sformatf("vec%0d pwm_out", i), pwm_out, vecs[i].pwm);
      chk1($sformatf("vec%0d evt_valid", i), evt_valid, vecs[i].ev);
      chk1($sformatf("vec%0d evt_overrun", i), evt_overrun, vecs[i].ov);
      chk1($sformatf("vec%0d cfg_ready", i), cfg_ready, vecs[i].cr);
      chk1($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
    end

    // Duty 64 loaded in IDLE, then 200 offered mid-period at count 100
    do_reset();
    cfg_valid = 1'b1; cfg_cmp = 8'd64;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    chk1("idle load cfg_ready low", cfg_ready, 1'b0);
    @(posedge clk);
    #1;
    chk1("idle apply cfg_ready", cfg_ready, 1'b1);
    cur_m = 8'd64;
    enable = 1'b1;
    run_period(-1, 8'd0, 0, "armed events");
    run_period(100, 8'd200, 1, "duty64 events");
    run_period(-1, 8'd0, 1, "duty200 events");

    // Consumer stalls for two periods
    evt_ready = 1'b0;
    run_period(10, 8'd64, 1, "stall p1 events");
    chk1("stall p1 evt_valid", evt_valid, 1'b1);
    chk1("stall p1 evt_overrun", evt_overrun, 1'b0);
    run_period(-1, 8'd0, 0, "stall p2 events");
    chk1("stall p2 evt_valid", evt_valid, 1'b1);
    chk1("stall p2 evt_overrun", evt_overrun, 1'b1);
    overrun_clr = 1'b1;
    cyc(8'd0, 1'b0, 8'd0);
    overrun_clr = 1'b0;
    chk1("overrun_clr evt_overrun", evt_overrun, 1'b0);
    chk1("overrun_clr evt_valid", evt_valid, 1'b1);
    evt_ready = 1'b1;
    cyc(8'd1, 1'b0, 8'd0);
    chk1("consume evt_valid", evt_valid, 1'b0);

    // Counter parks on the compare value for five cycles
    rises = 0;
    for (int c = 2; c < 64; c++) cyc(8'(c), 1'b0, 8'd0);
    repeat (5) cyc(8'd64, 1'b0, 8'd0);
    for (int c = 65; c < 256; c++) cyc(8'(c), 1'b0, 8'd0);
    chk_int("hold events", rises, 1);

    // Extreme compare values
    run_period(5, 8'd0, 1, "load0 events");
    run_period(5, 8'd255, 1, "cmp0 events");
    run_period(-1, 8'd0, 1, "cmp255 events");

    // Async reset mid-period with a value pending
    for (int c = 0; c < 150; c++) cyc(8'(c), (c == 100), 8'd10);
    cyc(8'd150, 1'b0, 8'd0);
    chk1("pre-rst cfg_ready", cfg_ready, 1'b0);
    #2 rst = 1'b0;
    enable = 1'b0;
    #1;
    chk1("async rst pwm_out", pwm_out, 1'b0);
    chk1("async rst evt_valid", evt_valid, 1'b0);
    chk1("async rst evt_overrun", evt_overrun, 1'b0);
    chk1("async rst busy", busy, 1'b0);
    chk1("async rst cfg_ready", cfg_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    enable = 1'b1;
    run_period(-1, 8'd0, 0, "post-rst armed events");
    run_period(-1, 8'd0, 1, "post-rst cmp0 events");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
